// File: rtl/daisy_master_pkg.sv
// daisy_master_pkg: shared state type, command codes and helpers for the
// daisychain bus master. Optional feature macro: DAISY_AUTO_UPDATE_EN.
`ifndef DATA_LEN
`define DATA_LEN 8
`endif
`ifndef CMD_LEN
`define CMD_LEN 2
`endif
`ifndef RESET_CMD
`define RESET_CMD (`CMD_LEN'(0))
`endif
`ifndef UPDATE_CMD
`define UPDATE_CMD (`CMD_LEN'(1))
`endif
`ifndef START_SND_CMD
`define START_SND_CMD (`CMD_LEN'(2))
`endif
`ifndef START_RCV_CMD
`define START_RCV_CMD (`CMD_LEN'(3))
`endif

package daisy_master_pkg;

   localparam int DATA_W = `DATA_LEN;
   localparam int CMD_W  = `CMD_LEN;
   localparam int TX_W   = (DATA_W > CMD_W) ? DATA_W : CMD_W;

   typedef enum logic [2:0] {
      IDLE,
      START,
      CMD,
      TURN,
      WR_DATA,
      RD_DATA,
      GAP
   } mst_state_t;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // The transmitter always shifts out of its MSB, so payloads are left-aligned.
   function automatic logic [TX_W-1:0] align_cmd(
      input logic [CMD_W-1:0] c
   );
      return TX_W'(c) << (TX_W - CMD_W);
   endfunction

   function automatic logic [TX_W-1:0] align_data(
      input logic [DATA_W-1:0] d
   );
      return TX_W'(d) << (TX_W - DATA_W);
   endfunction

endpackage

// File: rtl/daisy_bit_serdes.sv
// daisy_bit_serdes: phase down-counter, MSB-first transmit shifter with
// output enable, and LSB-ward receive shifter for the daisychain line.
module daisy_bit_serdes
   import daisy_master_pkg::*;
#(
   parameter int CNT_LEN = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [CNT_LEN-1:0] cnt_val,
   input  logic [TX_W-1:0]    tx_val,
   input  logic               oe_val,
   input  logic               tx_shift,
   input  logic               rx_shift,
   input  logic               line_in,
   output logic               line_out,
   output logic               line_oe,
   output logic               cnt_zero,
   output logic [DATA_W-1:0]  rx_next
);

   logic [CNT_LEN-1:0] cnt_q;
   logic [TX_W-1:0]    tx_q;
   logic [DATA_W-1:0]  rx_q;
   logic               oe_q;

   // Reset leaves the line actively driven low, not floating.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         tx_q  <= '0;
         oe_q  <= 1'b1;
         rx_q  <= '0;
      end else begin
         if (load) begin
            cnt_q <= cnt_val;
            tx_q  <= tx_val;
            oe_q  <= oe_val;
         end else begin
            if (cnt_q != '0) begin
               cnt_q <= cnt_q - 1'b1;
            end
            if (tx_shift) begin
               tx_q <= tx_q << 1;
            end
         end
         if (rx_shift) begin
            rx_q <= rx_next;
         end
      end
   end

   assign rx_next  = {rx_q[DATA_W-2:0], line_in};
   assign line_out = tx_q[TX_W-1];
   assign line_oe  = oe_q;
   assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/daisy_master.sv
// daisy_master: host-side single-wire daisychain bus master.
// Define DAISY_AUTO_UPDATE_EN to chain an UPDATE frame after every write.
module daisy_master
   import daisy_master_pkg::*;
#(
   parameter int TURN_CYC = 2,
   parameter int GAP_CYC  = 2,
   parameter int CNT_LEN  = $clog2(max_of(
      max_of(`DATA_LEN, `CMD_LEN),
      max_of(TURN_CYC, GAP_CYC)) + 1)
) (
   input  logic              clk,
   input  logic              reset,
   inout  wire logic         data_inout,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [CMD_W-1:0]  req_cmd,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic [2:0]        state_debug
);

`ifdef DAISY_AUTO_UPDATE_EN
   localparam bit AUTO_UPD = 1'b1;
`else
   localparam bit AUTO_UPD = 1'b0;
`endif

   localparam logic [CNT_LEN-1:0] CMD_LD  = CNT_LEN'(CMD_W - 1);
   localparam logic [CNT_LEN-1:0] TURN_LD = CNT_LEN'(TURN_CYC - 1);
   localparam logic [CNT_LEN-1:0] DATA_LD = CNT_LEN'(DATA_W - 1);
   localparam logic [CNT_LEN-1:0] GAP_LD  = CNT_LEN'(GAP_CYC - 1);

   mst_state_t         state_q, state_d;
   logic [CMD_W-1:0]   cmd_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [DATA_W-1:0]  rdata_q;
   logic               err_q;
   logic               gap_first_q;

   logic               accept;
   logic               req_known;
   logic               is_snd;
   logic               is_rcv;
   logic               auto_upd;

   logic               load;
   logic [CNT_LEN-1:0] cnt_val;
   logic [TX_W-1:0]    tx_val;
   logic               oe_val;
   logic               tx_shift;
   logic               rx_shift;
   logic               line_out;
   logic               line_oe;
   logic               line_in;
   logic               cnt_zero;
   logic [DATA_W-1:0]  rx_next;

   assign req_ready = (state_q == IDLE) && !reset;
   assign accept    = req_valid && req_ready;
   assign req_known = (req_cmd == `RESET_CMD)
                   || (req_cmd == `UPDATE_CMD)
                   || (req_cmd == `START_SND_CMD)
                   || (req_cmd == `START_RCV_CMD);

   always_comb begin
      is_snd = 1'b0;
      is_rcv = 1'b0;
      unique case (1'b1)
         (cmd_q == `START_SND_CMD): is_snd = 1'b1;
         (cmd_q == `START_RCV_CMD): is_rcv = 1'b1;
         default: ;
      endcase
   end

   // Every transition reloads counter, shifter and enable together.
   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      cnt_val  = '0;
      tx_val   = '0;
      oe_val   = 1'b1;
      tx_shift = 1'b0;
      rx_shift = 1'b0;
      auto_upd = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept && req_known) begin
               state_d = START;
               load    = 1'b1;
               tx_val  = '1;
            end
         end
         START: begin
            state_d = CMD;
            load    = 1'b1;
            cnt_val = CMD_LD;
            tx_val  = align_cmd(cmd_q);
         end
         CMD: begin
            if (cnt_zero) begin
               state_d = TURN;
               load    = 1'b1;
               cnt_val = TURN_LD;
               oe_val  = !is_snd;
            end else begin
               tx_shift = 1'b1;
            end
         end
         TURN: begin
            if (cnt_zero) begin
               load = 1'b1;
               unique case (1'b1)
                  is_snd: begin
                     state_d = RD_DATA;
                     cnt_val = DATA_LD;
                     oe_val  = 1'b0;
                  end
                  is_rcv: begin
                     state_d = WR_DATA;
                     cnt_val = DATA_LD;
                     tx_val  = align_data(wdata_q);
                  end
                  default: begin
                     state_d = GAP;
                     cnt_val = GAP_LD;
                  end
               endcase
            end else begin
               oe_val = !is_snd;
            end
         end
         WR_DATA: begin
            if (cnt_zero) begin
               state_d = GAP;
               load    = 1'b1;
               cnt_val = GAP_LD;
            end else begin
               tx_shift = 1'b1;
            end
         end
         RD_DATA: begin
            rx_shift = 1'b1;
            if (cnt_zero) begin
               state_d = GAP;
               load    = 1'b1;
               cnt_val = GAP_LD;
            end
         end
         GAP: begin
            if (cnt_zero) begin
               load = 1'b1;
               if (AUTO_UPD && is_rcv) begin
                  state_d  = START;
                  tx_val   = '1;
                  auto_upd = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            load    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cmd_q       <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         gap_first_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         err_q       <= accept && !req_known;
         gap_first_q <= (state_d == GAP) && (state_q != GAP);
         if (accept) begin
            cmd_q   <= req_cmd;
            wdata_q <= req_wdata;
         end else if (auto_upd) begin
            cmd_q <= `UPDATE_CMD;
         end
         if ((state_q == RD_DATA) && cnt_zero) begin
            rdata_q <= rx_next;
         end
      end
   end

   // A chained write reports once, from the UPDATE frame's gap.
   assign rsp_valid   = (gap_first_q && !(AUTO_UPD && is_rcv)) || err_q;
   assign rsp_err     = err_q;
   assign rsp_rdata   = rdata_q;
   assign busy        = (state_q != IDLE);
   assign state_debug = state_q;

   assign data_inout = line_oe ? line_out : 1'bz;
   assign line_in    = data_inout;

   daisy_bit_serdes #(
      .CNT_LEN (CNT_LEN)
   ) u_serdes (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .cnt_val  (cnt_val),
      .tx_val   (tx_val),
      .oe_val   (oe_val),
      .tx_shift (tx_shift),
      .rx_shift (rx_shift),
      .line_in  (line_in),
      .line_out (line_out),
      .line_oe  (line_oe),
      .cnt_zero (cnt_zero),
      .rx_next  (rx_next)
   );

endmodule

// File: tb/tb_daisy_master.sv
// tb_daisy_master: directed frame vectors with hand-derived per-cycle
// line, handshake and response expectations.
module tb_daisy_master;

   logic       clk;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_cmd;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic       rsp_err;
   logic [7:0] rsp_rdata;
   logic       busy;
   logic [2:0] state_debug;
   logic       drv_en;
   logic       drv;
   wire        line;

   int n_chk = 0;
   int n_err = 0;

   assign line = drv_en ? drv : 1'bz;

   daisy_master dut (
      .clk         (clk),
      .reset       (reset),
      .data_inout  (line),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_cmd     (req_cmd),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_err     (rsp_err),
      .rsp_rdata   (rsp_rdata),
      .busy        (busy),
      .state_debug (state_debug)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ln holds the expected line per cycle from cycle 1: '0', '1' or 'z'.
   task automatic run(input string      name,
                      input logic [1:0] cmd,
                      input logic [7:0] wd,
                      input logic [7:0] rd,
                      input string      ln,
                      input int         rsp_cyc,
                      input int         rdy_cyc,
                      input logic [7:0] exp_rd,
                      input bit         hold,
                      input int         rst_cyc);
      byte  c;
      logic e;
      logic er;
      bit   rd_mode;
      rd_mode = (cmd == 2'b10);
      @(negedge clk);
      req_cmd   = cmd;
      req_wdata = wd;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
      for (int k = 1; k <= ln.len(); k++) begin
         if (k > 1) begin
            @(posedge clk);
            #1;
         end
         drv_en = rd_mode && (k >= 6) && (k <= 13);
         drv    = (k >= 6 && k <= 13) ? rd[13-k] : 1'b0;
         reset  = (k == rst_cyc);
         if (hold && k == rdy_cyc + 1) req_valid = 1'b0;
         @(negedge clk);
         c = ln[k-1];
         if (c == "z") e = 1'bz;
         else          e = (c == "1");
         er = (k >= rdy_cyc) && !(hold && k > rdy_cyc);
         chk($sformatf("%s.line@%0d", name, k), 32'(line), 32'(e));
         chk($sformatf("%s.rsp_valid@%0d", name, k),
             32'(rsp_valid), 32'(k == rsp_cyc));
         chk($sformatf("%s.rsp_err@%0d", name, k), 32'(rsp_err), 32'(0));
         chk($sformatf("%s.ready@%0d", name, k), 32'(req_ready), 32'(er));
         chk($sformatf("%s.busy@%0d", name, k), 32'(busy), 32'(!er));
         if (k == rsp_cyc)
            chk($sformatf("%s.rdata", name), 32'(rsp_rdata), 32'(exp_rd));
      end
      drv_en    = 1'b0;
      reset     = 1'b0;
      req_valid = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 1'b0;
      req_cmd   = 2'b00;
      req_wdata = 8'h00;
      drv_en    = 1'b0;
      drv       = 1'b0;

      @(negedge clk);
      chk("rst.ready_in_reset", 32'(req_ready), 32'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst.ready", 32'(req_ready), 32'(1));
      chk("rst.line", 32'(line), 32'(0));
      chk("rst.rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst.rsp_err", 32'(rsp_err), 32'(0));
      chk("rst.rdata", 32'(rsp_rdata), 32'(0));
      chk("rst.busy", 32'(busy), 32'(0));
      chk("rst.state", 32'(state_debug), 32'(0));

`ifdef DAISY_AUTO_UPDATE_EN
      run("wr_auto", 2'b11, 8'hA5, 8'h00,
          "11100101001010010100000", 21, 23, 8'h00, 1'b0, 0);
`else
      run("wr", 2'b11, 8'hA5, 8'h00,
          "1110010100101000", 14, 16, 8'h00, 1'b0, 0);
`endif

      run("rd", 2'b10, 8'h00, 8'h3C,
          "110zz00111100000", 14, 16, 8'h3C, 1'b0, 0);

      // req_valid held high: the second UPDATE is taken only once IDLE.
      run("upd_hold", 2'b01, 8'h00, 8'h00,
          "101000001", 6, 8, 8'h3C, 1'b1, 0);
      for (int i = 0; i < 40 && busy; i++) @(negedge clk);
      chk("upd_hold.drain", 32'(busy), 32'(0));
      chk("upd_hold.rdata_kept", 32'(rsp_rdata), 32'(8'h3C));

      run("wr_rst", 2'b11, 8'hA5, 8'h00,
          "111001010000", 0, 10, 8'h00, 1'b0, 9);
      chk("wr_rst.state", 32'(state_debug), 32'(0));
      chk("wr_rst.rdata", 32'(rsp_rdata), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
